// File: rtl/cache_mem_arbiter_if.sv
// Word-wide main-memory port shared by the cache refill/writeback engines.
// The arbiter drives the master side; the memory controller drives the slave side.
interface cache_mem_arbiter_if #(
  parameter int unsigned AW = 32
) ();
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the main-memory port between I-cache refills and D-cache refills/writebacks,
// sequencing each line as a LINE_WORDS-word burst followed by a one-cycle done pulse.
module cache_mem_arbiter #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned AW         = 32
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          i_req,
  input  logic [AW-1:0]                 i_addr,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [AW-1:0]                 d_addr,
  input  logic [31:0]                   d_wdata,
  output logic [$clog2(LINE_WORDS)-1:0] d_widx,
  output logic [31:0]                   fill_data,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic                          i_fill_we,
  output logic                          d_fill_we,
  output logic                          i_done,
  output logic                          d_done,
  output logic                          busy,
  cache_mem_arbiter_if.master           mem
);

  localparam int unsigned IW = $clog2(LINE_WORDS);
  localparam logic [AW-1:0] ALIGN_MASK = AW'(LINE_WORDS * 4 - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] cnt, cnt_nx;
  logic [AW-1:0] base, base_nx;
  logic          side_d, side_d_nx;
  logic          last_d, last_d_nx;
  logic          pick_d;
  logic          xfer;
  logic          rd_ack;

  // On a tie the side opposite the previous grant wins, so D goes first after reset.
  assign pick_d = d_req && (!i_req || !last_d);
  assign xfer   = (state == I_RD) || (state == D_RD) || (state == D_WR);
  assign rd_ack = ((state == I_RD) || (state == D_RD)) && mem.mem_ack;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      side_d    <= 1'b0;
      last_d    <= 1'b0;
      fill_data <= '0;
      fill_idx  <= '0;
      i_fill_we <= 1'b0;
      d_fill_we <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      base      <= base_nx;
      side_d    <= side_d_nx;
      last_d    <= last_d_nx;
      i_fill_we <= (state == I_RD) && mem.mem_ack;
      d_fill_we <= (state == D_RD) && mem.mem_ack;
      if (rd_ack) begin
        fill_data <= mem.mem_rdata;
        fill_idx  <= cnt;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    base_nx   = base;
    side_d_nx = side_d;
    last_d_nx = last_d;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          side_d_nx = pick_d;
          last_d_nx = pick_d;
          cnt_nx    = '0;
          base_nx   = pick_d ? (d_addr & ~ALIGN_MASK) : (i_addr & ~ALIGN_MASK);
          state_nx  = pick_d ? (d_we ? D_WR : D_RD) : I_RD;
        end
      end
      I_RD, D_RD, D_WR: begin
        if (mem.mem_ack) begin
          cnt_nx = cnt + IW'(1);
          if (cnt == LAST_IDX) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req   = xfer;
    mem.mem_we    = (state == D_WR);
    mem.mem_addr  = xfer ? base + (AW'(cnt) << 2) : '0;
    mem.mem_wdata = (state == D_WR) ? d_wdata : '0;
    d_widx        = (state == D_WR) ? cnt : '0;
    i_done        = (state == DONE) && !side_d;
    d_done        = (state == DONE) && side_d;
    busy          = (state != IDLE);
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed transfers push expected memory
// handshakes, fill strobes and done pulses; a monitor pops and compares them.
module tb_cache_mem_arbiter;
  localparam int unsigned LW = 4;
  localparam int unsigned AW = 32;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata;
  logic [1:0]  d_widx, fill_idx;
  logic [31:0] fill_data;
  logic        i_fill_we, d_fill_we, i_done, d_done, busy;

  logic [31:0] rbase = 32'hA0;
  logic [31:0] wbase = 32'hD0;
  int          ack_mode = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } mem_t;
  typedef struct { logic d; logic [1:0] idx; logic [31:0] data; } fill_t;
  typedef struct { logic d; logic rd; } done_t;
  mem_t  exp_mem[$];
  fill_t exp_fill[$];
  done_t exp_done[$];

  cache_mem_arbiter_if #(.AW(AW)) mem ();

  cache_mem_arbiter #(.LINE_WORDS(LW), .AW(AW)) dut (
    .clock(clock), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_widx(d_widx), .fill_data(fill_data), .fill_idx(fill_idx),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_done(i_done), .d_done(d_done), .busy(busy),
    .mem(mem)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign mem.mem_rdata = rbase + ((mem.mem_addr >> 2) & 32'h3);
  assign d_wdata       = wbase + 32'(d_widx);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // memory acknowledge driver: 0 = never, 1 = every cycle, 2 = every other cycle
  initial begin
    mem.mem_ack = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (ack_mode)
        1:       mem.mem_ack = 1'b1;
        2:       mem.mem_ack = ~mem.mem_ack;
        default: mem.mem_ack = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    mem_t  m;
    fill_t f;
    done_t dn;
    forever begin
      @(negedge clock);
      if (mem.mem_req && mem.mem_ack) begin
        check("mem handshake expected", 64'(exp_mem.size() != 0), 1);
        if (exp_mem.size() != 0) begin
          m = exp_mem.pop_front();
          check("mem_addr", mem.mem_addr, m.addr);
          check("mem_we", mem.mem_we, m.we);
          if (m.we) check("mem_wdata", mem.mem_wdata, m.wdata);
        end
      end
      if (i_fill_we || d_fill_we) begin
        check("fill expected", 64'(exp_fill.size() != 0), 1);
        if (exp_fill.size() != 0) begin
          f = exp_fill.pop_front();
          check("fill side", {i_fill_we, d_fill_we}, f.d ? 2'b01 : 2'b10);
          check("fill_idx", fill_idx, f.idx);
          check("fill_data", fill_data, f.data);
        end
      end
      if (i_done || d_done) begin
        check("done expected", 64'(exp_done.size() != 0), 1);
        if (exp_done.size() != 0) begin
          dn = exp_done.pop_front();
          check("done side", {i_done, d_done}, dn.d ? 2'b01 : 2'b10);
          if (dn.rd)
            check("done with last fill", {i_fill_we, d_fill_we, fill_idx},
                  {(dn.d ? 2'b01 : 2'b10), 2'(LW - 1)});
          else
            check("no fill on write done", {i_fill_we, d_fill_we}, 2'b00);
        end
      end
      if (i_fill_we || d_fill_we || i_done || d_done)
        check("side exclusive", (i_fill_we | i_done) & (d_fill_we | d_done), 0);
    end
  end

  task automatic push_xfer(input logic d, input logic we, input logic [31:0] addr,
                           input logic [31:0] dbase);
    logic [31:0] b;
    b = addr & ~32'hF;
    for (int unsigned k = 0; k < LW; k++) begin
      exp_mem.push_back('{b + 4 * k, we, dbase + k});
      if (!we) exp_fill.push_back('{d, 2'(k), dbase + k});
    end
    exp_done.push_back('{d, !we});
  endtask

  task automatic run_i(input logic [31:0] addr, output int done_cyc);
    int t;
    i_addr = addr;
    i_req  = 1'b1;
    t = 0;
    do begin @(negedge clock); t++; end while (!i_done && t < 200);
    check("i_done within bound", i_done, 1);
    done_cyc = cyc;
    @(posedge clock); #1;
    i_req = 1'b0;
  endtask

  task automatic run_d(input logic we, input logic [31:0] addr);
    int t;
    d_addr = addr;
    d_we   = we;
    d_req  = 1'b1;
    t = 0;
    do begin @(negedge clock); t++; end while (!d_done && t < 200);
    check("d_done within bound", d_done, 1);
    @(posedge clock); #1;
    d_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    resetn = 1'b0;
    @(posedge clock); #1;
    check("reset ctrl outputs", {mem.mem_req, mem.mem_we, i_fill_we, d_fill_we,
                                 i_done, d_done, busy, fill_idx, d_widx}, 0);
    check("reset mem_addr", mem.mem_addr, 0);
    check("reset mem_wdata", mem.mem_wdata, 0);
    check("reset fill_data", fill_data, 0);
    resetn = 1'b1;
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      check(name, {busy, mem.mem_req}, 2'b00);
    end
  endtask

  initial begin : stimulus
    int c0, cd;
    repeat (2) @(posedge clock);
    do_reset();

    // ack pulses in IDLE with no requester must be ignored
    ack_mode = 1;
    check_idle("idle with ack", 4);

    // I-side line read, ack every cycle, plus minimum latency
    @(posedge clock); #1;
    rbase = 32'hA0;
    push_xfer(1'b0, 1'b0, 32'h0000_1234, rbase);
    c0 = cyc;
    run_i(32'h0000_1234, cd);
    check("i_done latency", cd - c0, LW + 1);

    // D-side writeback with memory stalling every other cycle
    ack_mode = 2;
    wbase = 32'hD0;
    push_xfer(1'b1, 1'b1, 32'h0000_2000, wbase);
    run_d(1'b1, 32'h0000_2000);
    check_idle("idle after d_done", 3);

    // First tie after reset: D then I
    do_reset();
    ack_mode = 1;
    rbase = 32'hB0;
    push_xfer(1'b1, 1'b0, 32'h0000_4008, rbase);
    push_xfer(1'b0, 1'b0, 32'h0000_3000, rbase);
    fork
      run_d(1'b0, 32'h0000_4008);
      run_i(32'h0000_3000, cd);
    join
    check_idle("idle after tie 1", 2);

    // D alone makes D the last grant, so the next tie goes to I
    @(posedge clock); #1;
    ack_mode = 2;
    wbase = 32'hE0;
    push_xfer(1'b1, 1'b1, 32'h0000_5000, wbase);
    run_d(1'b1, 32'h0000_5000);
    ack_mode = 1;
    rbase = 32'h60;
    push_xfer(1'b0, 1'b0, 32'h0000_6000, rbase);
    push_xfer(1'b1, 1'b0, 32'h0000_7000, rbase);
    fork
      run_d(1'b0, 32'h0000_7000);
      run_i(32'h0000_6000, cd);
    join
    check_idle("idle after tie 2", 2);

    // Reset after two of four acks aborts the I read
    @(posedge clock); #1;
    rbase = 32'hC0;
    for (int unsigned k = 0; k < 2; k++) begin
      exp_mem.push_back('{32'h8010 + 4 * k, 1'b0, 32'h0});
      exp_fill.push_back('{1'b0, 2'(k), rbase + k});
    end
    i_addr = 32'h0000_801C;
    i_req  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    resetn   = 1'b0;
    i_req    = 1'b0;
    ack_mode = 0;
    @(posedge clock); #1;
    check("abort mem_req/busy/i_done", {mem.mem_req, busy, i_done}, 3'b000);
    resetn = 1'b1;
    check_idle("idle after abort", 3);

    // Restart from the base address
    @(posedge clock); #1;
    ack_mode = 1;
    push_xfer(1'b0, 1'b0, 32'h0000_801C, rbase);
    run_i(32'h0000_801C, cd);

    check_idle("final idle", 4);
    check("mem queue drained", exp_mem.size(), 0);
    check("fill queue drained", exp_fill.size(), 0);
    check("done queue drained", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
